// File: rtl/amp_boot_seq_pkg.sv
// Shared types for the amplifier boot sequencer: FSM state encoding and the
// status byte layout fed back to the amp_cfg register bank.
package amp_boot_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWait,
        StFail,
        StGap,
        StDone,
        StError
    } amp_boot_state_e;

    typedef struct packed {
        logic       done_flag;
        logic       err_flag;
        logic       busy;
        logic [2:0] retry_cnt;
        logic [1:0] rsvd;
    } rb_amp_status_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/amp_boot_seq.sv
// Amplifier boot sequencer: snapshots N_BOOT boot bytes and streams them to the
// serial engine with per-byte timeout and whole-sequence retry.
module amp_boot_seq
    import amp_boot_seq_pkg::*;
#(
    parameter int unsigned N_BOOT      = 8,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned GAP_CYC     = 255,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter bit          AUTO_BOOT   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                amp_init,
    input  logic                abort,
    input  logic [N_BOOT*8-1:0] boot_mem,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic                tx_first,
    output logic                tx_last,
    input  logic                tx_ready,
    input  logic                resp_valid,
    input  logic                resp_nack,
    output logic                busy,
    output logic                done,
    output logic [7:0]          status
);

    localparam int unsigned IW = (N_BOOT > 1) ? $clog2(N_BOOT) : 1;
    localparam int unsigned TW = $clog2(max_u(GAP_CYC, TIMEOUT_CYC) + 1);
    localparam logic [IW-1:0] LastIdx     = IW'(N_BOOT - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] GapLast     = TW'(GAP_CYC - 1);
    localparam logic [2:0]    MaxRetry    = 3'(MAX_RETRY);

    amp_boot_state_e state_q, state_d;
    logic [7:0]      snap_q [N_BOOT];
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      retry_q, retry_d;
    logic            done_flag_q, done_flag_d;
    logic            err_flag_q, err_flag_d;
    logic            pend_q, pend_d;
    logic            init_q, auto_q, rise;
    logic [7:0]      cur_byte;
    rb_amp_status_t  status_s;

    assign rise = amp_init & ~init_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            done_flag_q <= 1'b0;
            err_flag_q  <= 1'b0;
            pend_q      <= 1'b0;
            init_q      <= 1'b0;
            auto_q      <= AUTO_BOOT;
            for (int k = 0; k < int'(N_BOOT); k++) snap_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            done_flag_q <= done_flag_d;
            err_flag_q  <= err_flag_d;
            pend_q      <= pend_d;
            init_q      <= amp_init;
            auto_q      <= 1'b0;
            if (state_q == StLoad) begin
                for (int k = 0; k < int'(N_BOOT); k++) snap_q[k] <= boot_mem[8*k +: 8];
            end
        end
    end

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < int'(N_BOOT); k++) begin
            if (idx_q == IW'(k)) cur_byte = snap_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = '0;
        retry_d     = retry_q;
        done_flag_d = done_flag_q;
        err_flag_d  = err_flag_q;
        pend_d      = pend_q;
        // A request arriving outside IDLE is held one deep until we get back there.
        if (rise && state_q != StIdle) pend_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (rise || pend_q || auto_q) begin
                    state_d = StLoad;
                    pend_d  = 1'b0;
                end
            end
            StLoad: begin
                idx_d       = '0;
                retry_d     = '0;
                done_flag_d = 1'b0;
                err_flag_d  = 1'b0;
                state_d     = StSend;
            end
            StSend: begin
                if (tx_ready) state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                if (resp_valid && !resp_nack) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSend;
                    end
                end else if (resp_valid || timer_q == TimeoutLast) begin
                    state_d = StFail;
                end
            end
            StFail: begin
                if (retry_q == MaxRetry) begin
                    state_d = StError;
                end else begin
                    if (retry_q != 3'd7) retry_d = retry_q + 3'd1;
                    state_d = StGap;
                end
            end
            StGap: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == GapLast) begin
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StDone: begin
                done_flag_d = 1'b1;
                state_d     = StIdle;
            end
            StError: begin
                err_flag_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) timer_d = '0;
        // Abort overrides everything decided above, including a same-cycle response.
        if (abort) begin
            state_d     = StIdle;
            pend_d      = 1'b0;
            timer_d     = '0;
            idx_d       = idx_q;
            retry_d     = retry_q;
            done_flag_d = done_flag_q;
            err_flag_d  = err_flag_q;
        end
    end

    assign tx_valid = (state_q == StSend);
    assign tx_data  = tx_valid ? cur_byte : 8'h00;
    assign tx_first = tx_valid && (idx_q == '0);
    assign tx_last  = tx_valid && (idx_q == LastIdx);
    assign busy     = (state_q == StLoad) || (state_q == StSend) || (state_q == StWait) ||
                      (state_q == StFail) || (state_q == StGap);
    assign done     = (state_q == StDone);

    assign status_s = '{
        done_flag: done_flag_q,
        err_flag:  err_flag_q,
        busy:      busy,
        retry_cnt: retry_q,
        rsvd:      2'b00
    };
    assign status = status_s;

endmodule

// File: tb/tb_amp_boot_seq.sv
// Directed bench for amp_boot_seq: an 8-byte instance for the main flows and a
// single-byte auto-boot instance for the reset/auto-start case.
module tb_amp_boot_seq;

    localparam int unsigned GapA  = 5;
    localparam int unsigned ToutA = 6;

    logic        clk = 1'b0;
    logic        rst, amp_init, abort, tx_ready, resp_valid, resp_nack;
    logic [63:0] boot_mem;
    logic [7:0]  tx_data, status;
    logic        tx_valid, tx_first, tx_last, busy, done;

    logic        rst_b, tx_ready_b, resp_valid_b;
    logic [7:0]  boot_mem_b, tx_data_b, status_b;
    logic        tx_valid_b, tx_first_b, tx_last_b, busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    amp_boot_seq #(
        .N_BOOT(8), .MAX_RETRY(1), .GAP_CYC(GapA), .TIMEOUT_CYC(ToutA), .AUTO_BOOT(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .amp_init(amp_init), .abort(abort), .boot_mem(boot_mem),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_first(tx_first), .tx_last(tx_last),
        .tx_ready(tx_ready), .resp_valid(resp_valid), .resp_nack(resp_nack),
        .busy(busy), .done(done), .status(status)
    );

    amp_boot_seq #(
        .N_BOOT(1), .MAX_RETRY(0), .GAP_CYC(2), .TIMEOUT_CYC(4), .AUTO_BOOT(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .amp_init(1'b0), .abort(1'b0), .boot_mem(boot_mem_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_first(tx_first_b),
        .tx_last(tx_last_b), .tx_ready(tx_ready_b), .resp_valid(resp_valid_b),
        .resp_nack(1'b0), .busy(busy_b), .done(done_b), .status(status_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = ack, 1 = nack, 2 = no response
    task automatic serve_byte(input logic [7:0] d, input logic f, input logic l, input int mode);
        int n = 0;
        while (!tx_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq($sformatf("byte_%02h", d), {tx_valid, tx_first, tx_last, tx_data},
                 {1'b1, f, l, d});
        tick();
        check_eq($sformatf("accept_%02h", d), tx_valid, 0);
        if (mode < 2) begin
            tick();
            resp_valid = 1'b1;
            resp_nack  = (mode == 1);
            tick();
            resp_valid = 1'b0;
            resp_nack  = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; rst_b = 1'b1;
        amp_init = 1'b0; abort = 1'b0; tx_ready = 1'b1; resp_valid = 1'b0; resp_nack = 1'b0;
        boot_mem = 64'h0706050403020100;
        tx_ready_b = 1'b1; resp_valid_b = 1'b0; boot_mem_b = 8'hA5;
        tick(); tick();
        check_eq("rst_outs", {tx_valid, tx_first, tx_last, tx_data, busy, done}, 0);
        check_eq("rst_status", status, 8'h00);
        check_eq("rst_b_outs", {tx_valid_b, busy_b, status_b}, 0);
        rst = 1'b0;
        tick(); tick();
        check_eq("idle_no_auto", busy, 0);

        // 1: basic sequence
        amp_init = 1'b1;
        tick();
        amp_init = 1'b0;
        check_eq("t1_load_valid", {busy, tx_valid}, 2'b10);
        tick();
        check_eq("t1_t2_valid", tx_valid, 1);
        for (int k = 0; k < 8; k++) serve_byte(8'(k), k == 0, k == 7, 0);
        check_eq("t1_done", {done, busy}, 2'b10);
        tick();
        check_eq("t1_done_low", done, 0);
        check_eq("t1_status", status, 8'h80);

        // 2: NACK byte 3, retry succeeds
        amp_init = 1'b1;
        tick();
        amp_init = 1'b0;
        for (int k = 0; k < 3; k++) serve_byte(8'(k), k == 0, 1'b0, 0);
        serve_byte(8'h03, 1'b0, 1'b0, 1);
        cnt = 0;
        while (!tx_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check_eq("t2_gap_len", cnt, GapA + 1);
        check_eq("t2_status_retry", status, 8'h24);
        for (int k = 0; k < 8; k++) serve_byte(8'(k), k == 0, k == 7, 0);
        check_eq("t2_done", done, 1);
        tick();
        check_eq("t2_status", status, 8'h84);

        // 3: no responses, MAX_RETRY=1 -> error
        amp_init = 1'b1;
        tick();
        amp_init = 1'b0;
        serve_byte(8'h00, 1'b1, 1'b0, 2);
        cnt = 0;
        while (!tx_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check_eq("t3_timeout_gap", cnt, ToutA + 1 + GapA);
        serve_byte(8'h00, 1'b1, 1'b0, 2);
        repeat (ToutA + 2) tick();
        check_eq("t3_status", status, 8'h44);
        check_eq("t3_idle", {busy, tx_valid}, 0);
        check_eq("t3_no_done", done_cnt, 2);

        // 4: snapshot isolation and pending request
        amp_init = 1'b1;
        tick();
        amp_init = 1'b0;
        for (int k = 0; k < 3; k++) serve_byte(8'(k), k == 0, 1'b0, 0);
        boot_mem = 64'h1716151413121110;
        amp_init = 1'b1;
        for (int k = 3; k < 8; k++) serve_byte(8'(k), 1'b0, k == 7, 0);
        check_eq("t4_done", done, 1);
        tick();
        check_eq("t4_idle", busy, 0);
        tick();
        check_eq("t4_reload", busy, 1);
        tick();
        check_eq("t4_resend", tx_valid, 1);
        amp_init = 1'b0;
        for (int k = 0; k < 8; k++) serve_byte(8'h10 + 8'(k), k == 0, k == 7, 0);
        tick();
        check_eq("t4_status", status, 8'h80);

        // 5: stall, then abort with a same-cycle response
        tx_ready = 1'b0;
        amp_init = 1'b1;
        tick();
        amp_init = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("t5_stall_%0d", i), {tx_valid, tx_first, tx_last, tx_data},
                     11'h610);
            if (i == 3) amp_init = 1'b1;
            tick();
        end
        abort = 1'b1; resp_valid = 1'b1;
        tick();
        abort = 1'b0; resp_valid = 1'b0;
        check_eq("t5_abort_idle", {busy, tx_valid}, 0);
        tick();
        check_eq("t5_pend_cleared", {busy, tx_valid}, 0);
        check_eq("t5_status", status, 8'h00);
        amp_init = 1'b0;
        tx_ready = 1'b1;
        tick();
        amp_init = 1'b1;
        tick();
        amp_init = 1'b0;
        tick();
        check_eq("t5b_send", tx_valid, 1);
        tick();
        check_eq("t5b_wait", {busy, tx_valid}, 2'b10);
        abort = 1'b1; resp_valid = 1'b1;
        tick();
        abort = 1'b0; resp_valid = 1'b0;
        check_eq("t5b_abort", busy, 0);
        tick();
        check_eq("t5b_resp_dropped", {busy, tx_valid}, 0);

        // 6: auto-boot, async reset in WAIT
        rst_b = 1'b0;
        tick();
        check_eq("t6_auto_load", busy_b, 1);
        tick();
        check_eq("t6_byte", {tx_valid_b, tx_first_b, tx_last_b, tx_data_b}, 11'h7A5);
        tick();
        check_eq("t6_wait", {busy_b, tx_valid_b}, 2'b10);
        #3 rst_b = 1'b1;
        #1;
        check_eq("t6_async_rst", {busy_b, tx_valid_b, done_b, status_b}, 0);
        tick();
        rst_b = 1'b0;
        tick();
        tick();
        check_eq("t6_rebyte", {tx_valid_b, tx_first_b, tx_last_b, tx_data_b}, 11'h7A5);
        tick();
        resp_valid_b = 1'b1;
        tick();
        resp_valid_b = 1'b0;
        check_eq("t6_done", done_b, 1);
        tick();
        check_eq("t6_status", {done_b, status_b}, 9'h080);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
